// File: rtl/eq_i2c_pkg.sv
// Constants and FSM encoding shared by the equalizer I2C control path.
package eq_i2c_pkg;

    localparam int         GAIN_W         = 8;
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h6A;
    localparam int         EQ_NUM_BANDS   = 10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_gain_regs_if.sv
// I2C pin bundle: raw SCL/SDA levels in, open-drain SDA pull-down enable out.
interface i2c_gain_regs_if;

    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edges plus START/STOP conditions.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic sda_s_o,
    output logic start_o,
    output logic stop_o
);

    // [0],[1] are the synchronizer pair, [2] holds the previous synchronized level
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    assign sda_s_o    = sda_q[1];
    assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_gain_regs.sv
// I2C responder holding one gain byte per equalizer band, with auto-incrementing
// register pointer for both write and read-back.
module i2c_gain_regs
    import eq_i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int         NUM_BANDS  = EQ_NUM_BANDS
) (
    input  logic                        clk,
    input  logic                        rst,
    i2c_gain_regs_if.slave              bus,
    output logic [GAIN_W*NUM_BANDS-1:0] gains,
    output logic                        gain_wr,
    output logic [3:0]                  gain_idx,
    output logic                        busy
);

    logic scl_rise, scl_fall, sda_s, start_ev, stop_ev;

    i2c_line_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (bus.scl_in),
        .sda_i      (bus.sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .sda_s_o    (sda_s),
        .start_o    (start_ev),
        .stop_o     (stop_ev)
    );

    i2c_state_t        state_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              rw_q;
    logic              ph_q;
    logic              sda_oe_q;
    logic              gain_wr_q;
    logic              busy_q;
    logic [3:0]        ptr_q;
    logic [3:0]        gain_idx_q;
    logic [GAIN_W-1:0] gain_q [NUM_BANDS];

    logic [7:0] rx_byte;
    logic [3:0] ptr_inc;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign ptr_inc = (ptr_q == 4'(NUM_BANDS - 1)) ? 4'd0 : ptr_q + 4'd1;

    // ph_q splits each ACK slot: 0 = waiting for the fall that opens it, 1 = slot open
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            ph_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            gain_wr_q  <= 1'b0;
            gain_idx_q <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
        end else begin
            gain_wr_q <= 1'b0;
            if (stop_ev) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                bit_q    <= '0;
                ph_q     <= 1'b0;
            end else if (start_ev) begin
                state_q  <= ST_ADDR;
                sda_oe_q <= 1'b0;
                bit_q    <= '0;
                ph_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte;
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                ph_q <= 1'b0;
                                if (state_q == ST_ADDR) begin
                                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                                        state_q <= ST_ADDR_ACK;
                                        rw_q    <= rx_byte[0];
                                        busy_q  <= 1'b1;
                                    end else begin
                                        state_q <= ST_IGNORE;
                                    end
                                end else if (state_q == ST_REG) begin
                                    if (rx_byte < 8'(NUM_BANDS)) begin
                                        state_q <= ST_REG_ACK;
                                        ptr_q   <= rx_byte[3:0];
                                    end else begin
                                        state_q <= ST_IGNORE;
                                    end
                                end else begin
                                    state_q <= ST_WDATA_ACK;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ph_q) begin
                                ph_q     <= 1'b1;
                                sda_oe_q <= 1'b1;
                                if (state_q == ST_WDATA_ACK) begin
                                    gain_wr_q  <= 1'b1;
                                    gain_idx_q <= ptr_q;
                                    ptr_q      <= ptr_inc;
                                end
                            end else begin
                                ph_q     <= 1'b0;
                                bit_q    <= '0;
                                sda_oe_q <= 1'b0;
                                if (state_q == ST_ADDR_ACK && rw_q) begin
                                    state_q  <= ST_RDATA;
                                    sda_oe_q <= ~gain_q[ptr_q][7];
                                end else if (state_q == ST_ADDR_ACK) begin
                                    state_q <= ST_REG;
                                end else begin
                                    state_q <= ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_q <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_q <= ST_RDATA_ACK;
                                ph_q    <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            sda_oe_q <= ~gain_q[ptr_q][~bit_q];
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_fall && !ph_q) begin
                            ph_q     <= 1'b1;
                            sda_oe_q <= 1'b0;
                        end else if (scl_rise && ph_q) begin
                            if (sda_s) state_q <= ST_IGNORE;
                            else       ptr_q   <= ptr_inc;
                        end else if (scl_fall && ph_q) begin
                            state_q  <= ST_RDATA;
                            ph_q     <= 1'b0;
                            bit_q    <= '0;
                            sda_oe_q <= ~gain_q[ptr_q][7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The received byte stays in shift_q through the ACK slot, so it is committed a cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_BANDS; k++) gain_q[k] <= '0;
        end else if (gain_wr_q) begin
            gain_q[gain_idx_q] <= shift_q;
        end
    end

    for (genvar k = 0; k < NUM_BANDS; k++) begin : g_pack
        assign gains[GAIN_W*k +: GAIN_W] = gain_q[k];
    end

    assign bus.sda_oe = sda_oe_q;
    assign gain_wr    = gain_wr_q;
    assign gain_idx   = gain_idx_q;
    assign busy       = busy_q;

endmodule
